score_ctrl: RTL and testbench

Score controller for the Tetris datapath. It arbitrates point-award requests from the line-clear logic and the drop logic and adds the points into a 4-digit packed-BCD score, one digit per cycle. It publishes the result on `score_out` only at frame boundaries, so the score renderer never shows a value that changes mid-frame. `score_out` feeds the score-digit display block directly.

---
 rtl/score_ctrl.sv | 111 +++++++++++
 tb/tb_score_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// score_ctrl: arbitrates line-clear/drop awards, adds them digit-serially into a BCD score,
// and publishes the score only on frame_start so the display never changes mid-frame.
module score_ctrl #(
    parameter logic [15:0] PTS1     = 16'h0100,
    parameter logic [15:0] PTS2     = 16'h0300,
    parameter logic [15:0] PTS3     = 16'h0500,
    parameter logic [15:0] PTS4     = 16'h0800,
    parameter logic [15:0] DROP_PTS = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_clr,
    input  logic        clear_req,
    input  logic [2:0]  clear_lines,
    output logic        clear_ack,
    input  logic        drop_req,
    output logic        drop_ack,
    input  logic        frame_start,
    output logic [15:0] score_out,
    output logic        busy
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ADD  = 1'b1;

    logic [0:0]  r_state, w_state_n;
    logic [15:0] r_work, w_work_n;
    logic [15:0] r_op, w_op_n;
    logic [15:0] w_score_n, w_pts;
    logic [1:0]  r_d, w_d_n;
    logic        r_c, w_c_n;
    logic        r_dirty, w_dirty_n;
    logic        w_cack_n, w_dack_n;
    logic [3:0]  w_wd, w_od, w_dig;
    logic [4:0]  w_s;

    assign w_pts = clear_lines == 3'd1 ? PTS1 :
                   clear_lines == 3'd2 ? PTS2 :
                   clear_lines == 3'd3 ? PTS3 :
                   clear_lines == 3'd4 ? PTS4 : 16'h0000;
    assign w_wd  = r_work[{r_d, 2'b00} +: 4];
    assign w_od  = r_op[{r_d, 2'b00} +: 4];
    assign w_s   = {1'b0, w_wd} + {1'b0, w_od} + {4'b0000, r_c};
    // s <= 19, so the 4-bit wraparound of s-10 yields the correct digit
    assign w_dig = w_s > 5'd9 ? w_s[3:0] - 4'd10 : w_s[3:0];

    always_comb begin
        w_state_n = r_state;
        w_work_n  = r_work;
        w_op_n    = r_op;
        w_score_n = score_out;
        w_d_n     = r_d;
        w_c_n     = r_c;
        w_dirty_n = r_dirty;
        w_cack_n  = 1'b0;
        w_dack_n  = 1'b0;
        if (game_clr) begin
            w_state_n = S_IDLE;
            w_work_n  = 16'h0000;
            w_score_n = 16'h0000;
            w_dirty_n = 1'b0;
        end else if (r_state == S_ADD) begin
            w_work_n[{r_d, 2'b00} +: 4] = w_dig;
            w_c_n = w_s > 5'd9;
            w_d_n = r_d + 2'd1;
            if (r_d == 2'd3) begin
                w_work_n  = w_s > 5'd9 ? 16'h9999 : w_work_n;
                w_dirty_n = r_dirty | (r_op != 16'h0000);
                w_state_n = S_IDLE;
            end
        end else begin
            if (frame_start && r_dirty) begin
                w_score_n = r_work;
                w_dirty_n = 1'b0;
            end
            if (clear_req || drop_req) begin
                w_state_n = S_ADD;
                w_d_n     = 2'd0;
                w_c_n     = 1'b0;
                w_cack_n  = clear_req;
                w_dack_n  = !clear_req;
                w_op_n    = clear_req ? w_pts : DROP_PTS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_work    <= 16'h0000;
            r_op      <= 16'h0000;
            r_d       <= 2'd0;
            r_c       <= 1'b0;
            r_dirty   <= 1'b0;
            score_out <= 16'h0000;
            clear_ack <= 1'b0;
            drop_ack  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_work    <= w_work_n;
            r_op      <= w_op_n;
            r_d       <= w_d_n;
            r_c       <= w_c_n;
            r_dirty   <= w_dirty_n;
            score_out <= w_score_n;
            clear_ack <= w_cack_n;
            drop_ack  <= w_dack_n;
            busy      <= (w_state_n == S_ADD) | w_dirty_n;
        end
    end
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: integer-arithmetic score model checked every cycle, plus literal checkpoints.
module tb_score_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, game_clr, clear_req, drop_req, frame_start;
    logic [2:0]  clear_lines;
    logic        clear_ack, drop_ack, busy;
    logic [15:0] score_out;
    int          errors = 0;
    int          checks = 0;

    score_ctrl dut (
        .clk(clk), .rst_n(rst_n), .game_clr(game_clr), .clear_req(clear_req),
        .clear_lines(clear_lines), .clear_ack(clear_ack), .drop_req(drop_req),
        .drop_ack(drop_ack), .frame_start(frame_start), .score_out(score_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: decimal integers, an add takes 4 cycles after the grant
    int m_work = 0, m_score = 0, m_left = 0, m_pts = 0;
    bit m_dirty = 0, m_cack = 0, m_dack = 0;

    function automatic int pts(input logic [2:0] l);
        case (l)
            3'd1: return 100;
            3'd2: return 300;
            3'd3: return 500;
            3'd4: return 800;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_work = 0; m_score = 0; m_left = 0; m_dirty = 0; m_cack = 0; m_dack = 0;
        end else begin
            m_cack = 0;
            m_dack = 0;
            if (game_clr) begin
                m_work = 0; m_score = 0; m_dirty = 0; m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_work = (m_work + m_pts > 9999) ? 9999 : m_work + m_pts;
                    if (m_pts != 0) m_dirty = 1;
                end
            end else begin
                if (frame_start && m_dirty) begin
                    m_score = m_work;
                    m_dirty = 0;
                end
                if (clear_req) begin
                    m_cack = 1; m_pts = pts(clear_lines); m_left = 4;
                end else if (drop_req) begin
                    m_dack = 1; m_pts = 1; m_left = 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("score_out", score_out, bcd(m_score));
        chk("clear_ack", 16'(clear_ack), 16'(m_cack));
        chk("drop_ack", 16'(drop_ack), 16'(m_dack));
        chk("busy", 16'(busy), 16'((m_left > 0) || m_dirty));
    end

    task automatic req(input bit clr, input bit drp, input logic [2:0] ln, output int n);
        clear_req = clr;
        drop_req = drp;
        clear_lines = ln;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(clear_ack || drop_ack) && n < 10);
        if (!(clear_ack || drop_ack)) chk("ack_timeout", 16'(n), 16'd0);
        if (clear_ack) clear_req = 1'b0;
        if (drop_ack) drop_req = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic award(input bit clr, input logic [2:0] ln);
        int n;
        req(clr, !clr, ln, n);
        repeat (4) @(negedge clk);
        frame();
    endtask

    task automatic clear_game();
        game_clr = 1'b1;
        @(negedge clk);
        game_clr = 1'b0;
    endtask

    initial begin
        int n, m;
        rst_n = 1'b0; game_clr = 1'b0; clear_req = 1'b0; drop_req = 1'b0;
        frame_start = 1'b0; clear_lines = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame();
        chk("idle_score", score_out, 16'h0000);

        req(1'b1, 1'b0, 3'd4, n);
        chk("ack_latency", 16'(n), 16'd1);
        repeat (4) @(negedge clk);
        chk("pre_frame_score", score_out, 16'h0000);
        chk("pre_frame_busy", 16'(busy), 16'd1);
        frame();
        chk("single_score", score_out, 16'h0800);
        chk("single_busy", 16'(busy), 16'd0);

        award(1'b1, 3'd2);
        chk("carry_score", score_out, 16'h1100);

        req(1'b1, 1'b1, 3'd1, n);
        chk("prio_clear_ack", 16'(clear_ack), 16'd1);
        chk("prio_drop_ack", 16'(drop_ack), 16'd0);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!drop_ack && m < 10);
        chk("drop_gap", 16'(m), 16'd5);
        drop_req = 1'b0;
        repeat (4) @(negedge clk);
        frame();
        chk("simul_score", score_out, 16'h1201);

        clear_game();
        for (int i = 0; i < 12; i++) award(1'b1, 3'd4);
        chk("sat12", score_out, 16'h9600);
        award(1'b1, 3'd4);
        chk("sat13", score_out, 16'h9999);
        award(1'b0, 3'd0);
        chk("sat_drop", score_out, 16'h9999);

        clear_game();
        req(1'b1, 1'b0, 3'd1, n);
        frame();
        chk("deferred_hold", score_out, 16'h0000);
        repeat (4) @(negedge clk);
        chk("deferred_still", score_out, 16'h0000);
        frame();
        chk("deferred_commit", score_out, 16'h0100);

        req(1'b1, 1'b0, 3'd4, n);
        clear_game();
        chk("abort_score", score_out, 16'h0000);
        chk("abort_busy", 16'(busy), 16'd0);
        repeat (2) @(negedge clk);
        frame();
        chk("abort_no_commit", score_out, 16'h0000);

        award(1'b1, 3'd2);
        chk("zero_pre", score_out, 16'h0300);
        req(1'b1, 1'b0, 3'd0, n);
        chk("zero_ack", 16'(clear_ack), 16'd1);
        repeat (4) @(negedge clk);
        chk("zero_busy", 16'(busy), 16'd0);
        frame();
        chk("zero_score", score_out, 16'h0300);

        req(1'b0, 1'b1, 3'd0, n);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_score", score_out, 16'h0000);
        chk("rst_acks", 16'({clear_ack, drop_ack}), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        frame();
        chk("rst_frame", score_out, 16'h0000);
        rst_n = 1'b1;
        award(1'b0, 3'd0);
        chk("post_rst_drop", score_out, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
